// File: rtl/rsa_div_pkg.sv
// Shared types for the RSA divider, its arbiter and the modexp sequencer.
// Holds the arbiter state encoding, the default divider width and the default divider latency bound.
package rsa_div_pkg;

   localparam int DIV_W = 1025;

   typedef enum logic [2:0] {
      DRAIN,
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } div_state_t;

   // Worst-case start-to-done distance of the non-restoring divider, with margin.
   function automatic int div_lat_default(input int w);
      return w + 4;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, cyclically.
// Zero latency; grant is one-hot or zero and hit flags that any request was found.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          hit
);

   function automatic logic [IW-1:0] wrap_idx(input int v);
      return IW'(v % N);
   endfunction

   always_comb begin
      grant = '0;
      idx   = '0;
      hit   = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!hit && req[wrap_idx(int'(ptr) + k)]) begin
            hit                              = 1'b1;
            grant[wrap_idx(int'(ptr) + k)]   = 1'b1;
            idx                              = wrap_idx(int'(ptr) + k);
         end
      end
   end

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin share of one start/done divider among N_REQ requesters; result one cycle after div_done.
// One division in flight; requests wait until the previous response is consumed via resp_ready.
module div_share_arbiter
   import rsa_div_pkg::*;
#(
   parameter int W       = DIV_W,
   parameter int N_REQ   = 2,
   parameter int DIV_LAT = div_lat_default(W)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*W-1:0]        req_dividend,
   input  logic [N_REQ*W-1:0]        req_divisor,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [$clog2(N_REQ)-1:0]  resp_id,
   output logic [W-1:0]              resp_quot,
   output logic [W-1:0]              resp_rem,
   output logic                      resp_err,
   output logic                      div_start,
   output logic [W-1:0]              div_q,
   output logic [W-1:0]              div_m,
   input  logic                      div_done,
   input  logic [W-1:0]              div_quot,
   input  logic [W-1:0]              div_rem
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(DIV_LAT + 1);

   div_state_t        state;
   div_state_t        state_nxt;
   logic [CW-1:0]     cnt;
   logic [IW-1:0]     rr_ptr;
   logic [N_REQ-1:0]  grant;
   logic [IW-1:0]     gidx;
   logic              hit;
   logic [W-1:0]      sel_dividend;
   logic [W-1:0]      sel_divisor;
   logic              div_zero;

   rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (gidx),
      .hit   (hit)
   );

   assign sel_dividend = req_dividend[int'(gidx)*W +: W];
   assign sel_divisor  = req_divisor[int'(gidx)*W +: W];
   assign div_zero     = (sel_divisor == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DRAIN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      div_start = 1'b0;
      case (state)
         // A timeout response is posted while draining; both must finish before new work.
         DRAIN: begin
            if ((cnt == '0) && (!resp_valid || resp_ready)) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            req_ready = grant;
            if (hit) begin
               state_nxt = div_zero ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            div_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (div_done) begin
               state_nxt = RESP;
            end else if (cnt == '0) begin
               state_nxt = DRAIN;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = DRAIN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= CW'(DIV_LAT);
         rr_ptr     <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_quot  <= '0;
         resp_rem   <= '0;
         resp_err   <= 1'b0;
         div_q      <= '0;
         div_m      <= '0;
      end else begin
         case (state)
            DRAIN: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end
               if (resp_valid && resp_ready) begin
                  resp_valid <= 1'b0;
               end
            end
            IDLE: begin
               if (hit) begin
                  div_q   <= sel_dividend;
                  div_m   <= sel_divisor;
                  resp_id <= gidx;
                  rr_ptr  <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                  if (div_zero) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_quot  <= '1;
                     resp_rem   <= sel_dividend;
                  end
               end
            end
            ISSUE: begin
               cnt <= CW'(DIV_LAT);
            end
            WAIT: begin
               if (div_done) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_quot  <= div_quot;
                  resp_rem   <= div_rem;
               end else if (cnt == '0) begin
                  // Divider presumed hung: report, then let it run out before reuse.
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_quot  <= '0;
                  resp_rem   <= '0;
                  cnt        <= CW'(DIV_LAT);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a behavioural divider of configurable latency.
module tb_div_share_arbiter;

   localparam int W       = 1025;
   localparam int N       = 2;
   localparam int DIV_LAT = W + 4;
   localparam int BOUND   = 3000;

   logic             clk;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_dividend;
   logic [N*W-1:0]   req_divisor;
   logic             resp_valid;
   logic             resp_ready;
   logic [0:0]       resp_id;
   logic [W-1:0]     resp_quot;
   logic [W-1:0]     resp_rem;
   logic             resp_err;
   logic             div_start;
   logic [W-1:0]     div_q;
   logic [W-1:0]     div_m;
   logic             div_done;
   logic [W-1:0]     div_quot;
   logic [W-1:0]     div_rem;

   div_share_arbiter #(.W(W), .N_REQ(N), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_quot(resp_quot), .resp_rem(resp_rem), .resp_err(resp_err),
      .div_start(div_start), .div_q(div_q), .div_m(div_m),
      .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (low 128 bits)", name, act[127:0], exp[127:0]);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural divider: no reset, optional withheld done, stray-done injection.
   int           model_lat   = 40;
   bit           no_done     = 0;
   bit           inject_done = 0;
   bit           busy        = 0;
   bit           track       = 0;
   int           cnt_m       = 0;
   int           n_starts    = 0;
   int           stab_err    = 0;
   logic [W-1:0] mq, mm;

   initial begin
      div_done = 1'b0;
      div_quot = '0;
      div_rem  = '0;
      mq       = '0;
      mm       = '0;
      forever begin
         @(negedge clk);
         div_done = 1'b0;
         if (busy && track && (div_q !== mq || div_m !== mm)) stab_err++;
         if (inject_done) begin
            inject_done = 0;
            div_done    = 1'b1;
            div_quot    = {W{1'b1}};
            div_rem     = {W{1'b1}};
         end else if (busy) begin
            if (cnt_m == 0) begin
               busy = 0;
               if (!no_done) begin
                  div_done = 1'b1;
                  div_quot = mq / mm;
                  div_rem  = mq % mm;
               end
            end else begin
               cnt_m--;
            end
         end
         if (div_start) begin
            busy  = 1;
            track = 1;
            cnt_m = model_lat - 1;
            mq    = div_q;
            mm    = div_m;
            n_starts++;
         end
      end
   end

   task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int wait_cyc, output bit ok);
      req_dividend[id*W +: W] = a;
      req_divisor[id*W +: W]  = b;
      req_valid[id]           = 1'b1;
      wait_cyc = 0;
      #1;
      while (!req_ready[id] && wait_cyc < BOUND) begin
         @(negedge clk);
         #1;
         wait_cyc++;
      end
      ok = req_ready[id];
      @(posedge clk);
      @(negedge clk);
      req_valid[id] = 1'b0;
   endtask

   task automatic recv(output int wait_cyc, output bit ok);
      wait_cyc = 0;
      while (!resp_valid && wait_cyc < BOUND) begin
         @(negedge clk);
         wait_cyc++;
      end
      ok = resp_valid;
   endtask

   task automatic ack();
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   typedef struct {
      int           id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      bit           err;
   } vec_t;

   vec_t         vt[8];
   logic [W-1:0] big, big_q, ones;

   initial begin : main
      int  wc, wc2, starts0, bad, g;
      bit  ok, ok2;
      logic [W-1:0] hq, hr;
      logic [0:0]   hid;

      ones  = {W{1'b1}};
      big   = '0;
      big[1024] = 1'b1;
      big   = big + 5;
      big_q = '0;
      big_q[1023:0] = {256{4'h5}};
      big_q = big_q + 2;

      vt[0] = '{0, W'(100),  W'(7),    W'(14),   W'(2),    0};
      vt[1] = '{1, W'(9),    W'(4),    W'(2),    W'(1),    0};
      vt[2] = '{0, W'(85),   W'(0),    ones,     W'(85),   1};
      vt[3] = '{1, big,      W'(3),    big_q,    W'(0),    0};
      vt[4] = '{0, W'(5),    W'(10),   W'(0),    W'(5),    0};
      vt[5] = '{1, ones,     W'(1),    ones,     W'(0),    0};
      vt[6] = '{0, W'(1000), W'(1000), W'(1),    W'(0),    0};
      vt[7] = '{1, W'(0),    W'(0),    ones,     W'(0),    1};

      rst          = 1'b1;
      req_valid    = '0;
      req_dividend = '0;
      req_divisor  = '0;
      resp_ready   = 1'b0;

      // Reset values, with a request already pending.
      repeat (3) @(negedge clk);
      req_valid[0] = 1'b1;
      #1;
      check("rst_req_ready",  W'(req_ready), W'(0));
      check("rst_resp_valid", W'(resp_valid), W'(0));
      check("rst_resp_err",   W'(resp_err), W'(0));
      check("rst_div_start",  W'(div_start), W'(0));
      check("rst_resp_id",    W'(resp_id), W'(0));
      check("rst_resp_quot",  resp_quot, W'(0));
      check("rst_resp_rem",   resp_rem, W'(0));
      check("rst_div_q",      div_q, W'(0));
      check("rst_div_m",      div_m, W'(0));

      // Post-reset drain holds off the first request; full-length divider.
      @(negedge clk);
      rst       = 1'b0;
      model_lat = W + 2;
      send(0, W'(100), W'(7), wc, ok);
      check_int("drain_accept", int'(ok), 1);
      check_int("drain_hold_ge_lat", int'(wc >= DIV_LAT), 1);
      recv(wc, ok);
      check_int("t1_resp_valid", int'(ok), 1);
      check_int("t1_id", int'(resp_id), 0);
      check("t1_quot", resp_quot, W'(14));
      check("t1_rem",  resp_rem,  W'(2));
      check_int("t1_err", int'(resp_err), 0);
      ack();
      model_lat = 40;

      for (int i = 0; i < 8; i++) begin
         starts0 = n_starts;
         send(vt[i].id, vt[i].a, vt[i].b, wc, ok);
         check_int($sformatf("v%0d_accept", i), int'(ok), 1);
         recv(wc, ok);
         check_int($sformatf("v%0d_valid", i), int'(ok), 1);
         check_int($sformatf("v%0d_id", i), int'(resp_id), vt[i].id);
         check($sformatf("v%0d_quot", i), resp_quot, vt[i].q);
         check($sformatf("v%0d_rem", i), resp_rem, vt[i].r);
         check_int($sformatf("v%0d_err", i), int'(resp_err), int'(vt[i].err));
         if (vt[i].err) begin
            check_int($sformatf("v%0d_no_start", i), n_starts, starts0);
            check_int($sformatf("v%0d_fast", i), int'(wc <= 2), 1);
         end
         ack();
      end

      // Fairness: both requesters continuously valid; last grant was 1, so 0 comes next.
      req_dividend[0*W +: W] = big;
      req_divisor[0*W +: W]  = W'(3);
      req_dividend[1*W +: W] = W'(100);
      req_divisor[1*W +: W]  = W'(7);
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wc = 0;
         #1;
         while (req_ready == '0 && wc < BOUND) begin
            @(negedge clk);
            #1;
            wc++;
         end
         check($sformatf("rr_grant%0d", k), W'(req_ready), W'(1 << (k % 2)));
         g = req_ready[1] ? 1 : 0;
         @(posedge clk);
         @(negedge clk);
         recv(wc, ok);
         check_int($sformatf("rr_valid%0d", k), int'(ok), 1);
         check_int($sformatf("rr_id%0d", k), int'(resp_id), g);
         check($sformatf("rr_quot%0d", k), resp_quot, (g == 0) ? big_q : W'(14));
         check($sformatf("rr_rem%0d", k), resp_rem, (g == 0) ? W'(0) : W'(2));
         ack();
      end
      req_valid = '0;

      // Watchdog: divider never answers.
      no_done = 1;
      send(0, W'(77), W'(5), wc, ok);
      check_int("wd_accept", int'(ok), 1);
      recv(wc, ok);
      check_int("wd_valid", int'(ok), 1);
      check_int("wd_after_lat", int'(wc >= DIV_LAT), 1);
      check_int("wd_err", int'(resp_err), 1);
      check("wd_quot", resp_quot, W'(0));
      check("wd_rem",  resp_rem,  W'(0));
      ack();
      no_done = 0;
      send(1, W'(9), W'(4), wc, ok);
      check_int("wd_next_accept", int'(ok), 1);
      check_int("wd_drain_hold", int'(wc >= DIV_LAT - 3), 1);
      recv(wc, ok);
      check("wd_next_quot", resp_quot, W'(2));
      check("wd_next_rem",  resp_rem,  W'(1));
      check_int("wd_next_err", int'(resp_err), 0);
      ack();

      // Response backpressure for 50 cycles with another requester waiting.
      send(0, W'(1000), W'(7), wc, ok);
      recv(wc, ok);
      check("bp_quot", resp_quot, W'(142));
      check("bp_rem",  resp_rem,  W'(6));
      hq  = resp_quot;
      hr  = resp_rem;
      hid = resp_id;
      req_dividend[1*W +: W] = W'(9);
      req_divisor[1*W +: W]  = W'(4);
      req_valid[1] = 1'b1;
      starts0 = n_starts;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (!resp_valid || resp_quot !== hq || resp_rem !== hr || resp_id !== hid ||
             resp_err !== 1'b0 || req_ready !== '0 || div_start !== 1'b0) bad++;
      end
      check_int("bp_stable_cycles_bad", bad, 0);
      check_int("bp_no_start", n_starts, starts0);
      ack();
      send(1, W'(9), W'(4), wc, ok);
      check_int("bp_next_accept", int'(ok), 1);
      recv(wc, ok);
      check_int("bp_next_id", int'(resp_id), 1);
      check("bp_next_quot", resp_quot, W'(2));
      ack();

      // Reset while WAITing; divider keeps running and also gets a stray done.
      send(0, W'(100), W'(7), wc, ok);
      repeat (10) @(negedge clk);
      track = 0;
      rst   = 1'b1;
      #1;
      check_int("mid_rst_resp_valid", int'(resp_valid), 0);
      check_int("mid_rst_div_start", int'(div_start), 0);
      check("mid_rst_div_q", div_q, W'(0));
      check("mid_rst_div_m", div_m, W'(0));
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (c == 5) inject_done = 1;
         if (resp_valid !== 1'b0 || req_ready !== '0) bad++;
      end
      check_int("mid_rst_quiet_bad", bad, 0);
      send(1, W'(9), W'(4), wc, ok);
      check_int("mid_rst_accept", int'(ok), 1);
      recv(wc, ok);
      check_int("mid_rst_valid", int'(ok), 1);
      check_int("mid_rst_id", int'(resp_id), 1);
      check("mid_rst_quot", resp_quot, W'(2));
      check("mid_rst_rem",  resp_rem,  W'(1));
      check_int("mid_rst_err", int'(resp_err), 0);
      ack();

      check_int("div_operands_stable", stab_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
